// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute controller for the accumulator datapath.
// Moore FSM; every strobe is a register loaded from the next state, so outputs are glitch-free
// and line up with state_dbg. Also keeps a retired-instruction counter and a sticky
// illegal-opcode flag for debug.
//
// Optional feature macro: CTRL_SINGLE_STEP_EN -- adds the `step` input. Every entry into F1
// that is not from IDLE then waits in F1 with all strobes low until step=1 is seen on an edge.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               leave IDLE and begin fetching (sampled only in IDLE)
//   instr[3:0]          opcode from IR[15:12]
//   acc_zero            ACC == 0, sampled only in DEC
//   step                single-step advance (CTRL_SINGLE_STEP_EN only)
//   arload .. ac_inc    datapath strobes
//   alusel[2:0]         ALU op (000 add, 001 sub, 010 and, 011 or, 100 xor, 111 pass DR)
//   halted              high in HALT
//   illegal             sticky, set when DEC sees opcode B..E
//   retired[CNT_W-1:0]  completed-instruction count, wraps
//   state_dbg[3:0]      current state code
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       instr,
  input  logic             acc_zero,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             arload,
  output logic             pcload,
  output logic             pcinc,
  output logic             pcbus,
  output logic             drload,
  output logic             drbus,
  output logic             irload,
  output logic             membus,
  output logic             memwrite,
  output logic             acbus,
  output logic             ac_load,
  output logic             ac_inc,
  output logic [2:0]       alusel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    StIdle = 4'h0,
    StF1   = 4'h1,
    StF2   = 4'h2,
    StF3   = 4'h3,
    StDec  = 4'h4,
    StLd1  = 4'h5,
    StLd2  = 4'h6,
    StAl1  = 4'h7,
    StAl2  = 4'h8,
    StSt1  = 4'h9,
    StJp1  = 4'hA,
    StInc  = 4'hB,
    StHalt = 4'hF
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_code_q;
  logic       hold_q;
  logic       f1_run_d;    // next state is F1 with its strobes enabled
  logic       ret_evt;     // an instruction completes on this edge
  logic       illegal_set;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StF1;
      StF1:   if (!hold_q) state_d = StF2;
      StF2:   state_d = StF3;
      StF3:   state_d = StDec;
      StDec: begin
        case (instr)
          4'h0:                         state_d = StF1;
          4'h1:                         state_d = StLd1;
          4'h2:                         state_d = StSt1;
          4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = StAl1;
          4'h8:                         state_d = StJp1;
          4'h9:                         state_d = acc_zero ? StJp1 : StF1;
          4'hA:                         state_d = StInc;
          4'hF:                         state_d = StHalt;
          default:                      state_d = StF1;  // B..E behave as NOP
        endcase
      end
      StLd1:  state_d = StLd2;
      StAl1:  state_d = StAl2;
      StLd2, StAl2, StSt1, StJp1, StInc: state_d = StF1;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // IDLE->F1 is a start, not a completion, so it is excluded here.
  assign ret_evt = ((state_d == StF1) &&
                    (state_q inside {StDec, StLd2, StAl2, StSt1, StJp1, StInc})) ||
                   ((state_d == StHalt) && (state_q == StDec));

  assign illegal_set = (state_q == StDec) && (instr inside {[4'hB:4'hE]});

`ifdef CTRL_SINGLE_STEP_EN
  logic hold_d;

  always_comb begin
    hold_d = hold_q;
    if ((state_q == StF1) && hold_q && step) hold_d = 1'b0;
    if (ret_evt && (state_d == StF1)) hold_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_d;
  end

  assign f1_run_d = (state_d == StF1) && !hold_d;
`else
  assign hold_q   = 1'b0;
  assign f1_run_d = (state_d == StF1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alu_code_q <= 3'b000;
      arload     <= 1'b0;
      pcload     <= 1'b0;
      pcinc      <= 1'b0;
      pcbus      <= 1'b0;
      drload     <= 1'b0;
      drbus      <= 1'b0;
      irload     <= 1'b0;
      membus     <= 1'b0;
      memwrite   <= 1'b0;
      acbus      <= 1'b0;
      ac_load    <= 1'b0;
      ac_inc     <= 1'b0;
      alusel     <= 3'b000;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      retired    <= '0;
    end else begin
      state_q  <= state_d;
      // Opcodes 3..7 map to ALU codes 0..4; IR is not reloaded before AL2 so this stays valid.
      if (state_q == StDec) alu_code_q <= instr[2:0] - 3'd3;
      arload   <= f1_run_d || (state_d == StF3);
      pcload   <= (state_d == StJp1);
      pcinc    <= (state_d == StF2);
      pcbus    <= f1_run_d;
      drload   <= (state_d inside {StF2, StLd1, StAl1});
      drbus    <= (state_d inside {StF3, StJp1});
      irload   <= (state_d == StF3);
      membus   <= (state_d inside {StF2, StLd1, StAl1});
      memwrite <= (state_d == StSt1);
      acbus    <= (state_d == StSt1);
      ac_load  <= (state_d inside {StLd2, StAl2});
      ac_inc   <= (state_d == StInc);
      alusel   <= (state_d == StLd2) ? 3'b111 :
                  (state_d == StAl2) ? alu_code_q : 3'b000;
      halted   <= (state_d == StHalt);
      if (illegal_set) illegal <= 1'b1;
      if (ret_evt) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state_dbg = state_q;

endmodule
